hazard_scoreboard: RTL and testbench

//  Parametrised hazard unit for the 5-stage MIPS core; generalises the combinational
//  ID-stage interlock into a per-register scoreboard of countdown counters.

---
 rtl/hazard_scoreboard.sv | 117 +++++++++++
 tb/tb_hazard_scoreboard.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage interlock built from per-register countdown
// counters. Each GPR holds the number of cycles before its pending result
// can be consumed. A separate counter tracks how long HI/LO stay busy.
// Optional feature macro: HAZ_PERF_EN adds a saturating stall-cycle counter
// and the stall_cycles output.
module hazard_scoreboard #(
  parameter int NREGS    = 32,
  parameter int REG_AW   = 5,
  parameter int ALU_LAT  = 1,
  parameter int LOAD_LAT = 2,
  parameter int MDU_LAT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_en,
  input  logic              id_rt_en,
  input  logic              id_early,
  input  logic              id_dst_en,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_is_load,
  input  logic              id_mdu_start,
  input  logic              id_mdu_read,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              control_dst,
  output logic [1:0]        stall_cause
`ifdef HAZ_PERF_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int MAX_LAT = (LOAD_LAT > MDU_LAT) ? LOAD_LAT : MDU_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  // Entry 0 exists only so id_rs/id_rt can index directly; it is held at zero.
  logic [CNT_W-1:0] cnt_q [NREGS];
  logic [CNT_W-1:0] cnt_d [NREGS];
  logic [CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;

  logic rs_hit, rt_hit, mdu_hit, opnd_hit, stall, issue;

  // Hazard detection: purely combinational from registered counters and ID inputs.
  // A non-early consumer picks the value up from EX forwarding, so a count of 1
  // is already safe for it; an early (ID-stage) consumer needs the count at 0.
  always_comb begin
    rs_hit   = id_rs_en && (id_rs != '0) &&
               (id_early ? (cnt_q[id_rs] != '0) : (cnt_q[id_rs] > CNT_W'(1)));
    rt_hit   = id_rt_en && (id_rt != '0) &&
               (id_early ? (cnt_q[id_rt] != '0) : (cnt_q[id_rt] > CNT_W'(1)));
    mdu_hit  = (mdu_cnt_q != '0) && (id_mdu_start || id_mdu_read);
    opnd_hit = rs_hit || rt_hit;
    stall    = id_valid && (opnd_hit || mdu_hit);
    issue    = id_valid && !stall;
  end

  // Pipeline control outputs; MDU busy outranks operand causes, early outranks EX.
  always_comb begin
    pc_write    = !stall;
    if_id_write = !stall;
    control_dst = !stall;
    stall_cause = 2'b00;
    if (stall) begin
      if (mdu_hit)       stall_cause = 2'b11;
      else if (id_early) stall_cause = 2'b10;
      else               stall_cause = 2'b01;
    end
  end

  // Next counter values: drain every busy counter, then let an issuing producer
  // overwrite its destination (the load wins over the decrement).
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CNT_W'(1) : '0;
      if (r != 0 && issue && id_dst_en && id_dst == REG_AW'(r))
        cnt_d[r] = id_is_load ? CNT_W'(LOAD_LAT) : CNT_W'(ALU_LAT);
    end
    cnt_d[0] = '0;
    mdu_cnt_d = (mdu_cnt_q != '0) ? mdu_cnt_q - CNT_W'(1) : '0;
    if (issue && id_mdu_start)
      mdu_cnt_d = CNT_W'(MDU_LAT);
  end

  // Counter registers; reset clears every pending hazard at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) cnt_q[r] <= '0;
      mdu_cnt_q <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

`ifdef HAZ_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // Count stalled cycles, sticking at all-ones rather than wrapping.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && stall_cycles_q != 32'hFFFF_FFFF)
      stall_cycles_d = stall_cycles_q + 32'd1;
  end

  // Performance counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cycles_q <= '0;
    else        stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: producer/consumer pairs with
// hand-computed bubble counts and stall causes.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_dst = '0;
  logic       id_rs_en = 1'b0, id_rt_en = 1'b0, id_early = 1'b0;
  logic       id_dst_en = 1'b0, id_is_load = 1'b0;
  logic       id_mdu_start = 1'b0, id_mdu_read = 1'b0;
  logic       pc_write, if_id_write, control_dst;
  logic [1:0] stall_cause;
`ifdef HAZ_PERF_EN
  logic [31:0] stall_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_perf = 0;
  logic [2:0] exp_q[$];

  hazard_scoreboard dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rs_en     (id_rs_en),
    .id_rt_en     (id_rt_en),
    .id_early     (id_early),
    .id_dst_en    (id_dst_en),
    .id_dst       (id_dst),
    .id_is_load   (id_is_load),
    .id_mdu_start (id_mdu_start),
    .id_mdu_read  (id_mdu_read),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .control_dst  (control_dst),
    .stall_cause  (stall_cause)
`ifdef HAZ_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, got timeout, wanted finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: present one instruction in ID.
  task automatic set_id(input logic v, input logic [4:0] rs, input logic rs_en,
                        input logic [4:0] rt, input logic rt_en, input logic early,
                        input logic [4:0] dst, input logic dst_en, input logic load,
                        input logic mstart, input logic mread);
    id_valid = v; id_rs = rs; id_rs_en = rs_en; id_rt = rt; id_rt_en = rt_en;
    id_early = early; id_dst = dst; id_dst_en = dst_en; id_is_load = load;
    id_mdu_start = mstart; id_mdu_read = mread;
  endtask

  task automatic lw(input logic [4:0] dst);
    set_id(1, 5'd1, 1, 5'd0, 0, 0, dst, 1, 1, 0, 0);
  endtask
  task automatic add(input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt);
    set_id(1, rs, 1, rt, 1, 0, dst, 1, 0, 0, 0);
  endtask
  task automatic beq(input logic [4:0] rs, input logic [4:0] rt);
    set_id(1, rs, 1, rt, 1, 1, 5'd0, 0, 0, 0, 0);
  endtask
  task automatic mult(input logic [4:0] rs, input logic [4:0] rt);
    set_id(1, rs, 1, rt, 1, 0, 5'd0, 0, 0, 1, 0);
  endtask
  task automatic mflo(input logic [4:0] dst);
    set_id(1, 5'd0, 0, 5'd0, 0, 0, dst, 1, 0, 0, 1);
  endtask
  task automatic idle();
    set_id(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
  endtask

  // Scoreboard step: queue the expected stall/cause, compare at the falling
  // edge, then advance through the rising edge.
  task automatic expect_cycle(input string tag, input logic st, input logic [1:0] cause);
    logic [2:0] e;
    exp_q.push_back({st, cause});
    @(negedge clk);
    e = exp_q.pop_front();
    check({tag, "_pc"},    {31'd0, pc_write},    {31'd0, ~e[2]});
    check({tag, "_ifid"},  {31'd0, if_id_write}, {31'd0, ~e[2]});
    check({tag, "_ctl"},   {31'd0, control_dst}, {31'd0, ~e[2]});
    check({tag, "_cause"}, {30'd0, stall_cause}, {30'd0, e[1:0]});
    if (e[2]) exp_perf++;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    idle();
    repeat (5) expect_cycle("idle", 0, 2'b00);
  endtask

  task automatic check_perf(input string tag);
`ifdef HAZ_PERF_EN
    check(tag, stall_cycles, exp_perf);
`endif
  endtask

  initial begin
    idle();
    #3;
    check("rst_pc",    {31'd0, pc_write},    32'd1);
    check("rst_ctl",   {31'd0, control_dst}, 32'd1);
    check("rst_cause", {30'd0, stall_cause}, 32'd0);
    check_perf("rst_perf");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: lw r8; add r9,r8,r1 -> one EX-operand bubble.
    lw(5'd8);               expect_cycle("t1_lw", 0, 2'b00);
    add(5'd9, 5'd8, 5'd1);  expect_cycle("t1_stall", 1, 2'b01);
                            expect_cycle("t1_issue", 0, 2'b00);
    drain();

    // T2: lw r8; beq r8,r0 -> two early-operand bubbles.
    lw(5'd8);               expect_cycle("t2_lw", 0, 2'b00);
    beq(5'd8, 5'd0);        expect_cycle("t2_stall1", 1, 2'b10);
                            expect_cycle("t2_stall2", 1, 2'b10);
                            expect_cycle("t2_issue", 0, 2'b00);
    drain();

    // T3: add r8; beq r8,r9 -> one bubble. add r8; add r10,r8 -> none.
    add(5'd8, 5'd2, 5'd3);  expect_cycle("t3_add", 0, 2'b00);
    beq(5'd8, 5'd9);        expect_cycle("t3_stall", 1, 2'b10);
                            expect_cycle("t3_issue", 0, 2'b00);
    drain();
    add(5'd8, 5'd2, 5'd3);  expect_cycle("t3_add2", 0, 2'b00);
    add(5'd10, 5'd8, 5'd2); expect_cycle("t3_fwd", 0, 2'b00);
    drain();

    // Self-dependency: add r8,r8,r2 reloads r8, so the following beq stalls once.
    add(5'd8, 5'd2, 5'd3);  expect_cycle("sd_add", 0, 2'b00);
    add(5'd8, 5'd8, 5'd2);  expect_cycle("sd_self", 0, 2'b00);
    beq(5'd8, 5'd0);        expect_cycle("sd_stall", 1, 2'b10);
                            expect_cycle("sd_issue", 0, 2'b00);
    drain();

    // T4: mult; mflo -> four MDU bubbles.
    mult(5'd2, 5'd3);       expect_cycle("t4_mult", 0, 2'b00);
    mflo(5'd4);
    for (int i = 0; i < 4; i++) expect_cycle("t4_stall", 1, 2'b11);
                            expect_cycle("t4_issue", 0, 2'b00);
    drain();

    // T4b: MDU busy and early operand hazard together -> MDU cause wins.
    mult(5'd2, 5'd3);       expect_cycle("t4b_mult", 0, 2'b00);
    add(5'd8, 5'd2, 5'd3);  expect_cycle("t4b_add", 0, 2'b00);
    set_id(1, 5'd8, 1, 5'd0, 0, 1, 5'd0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) expect_cycle("t4b_stall", 1, 2'b11);
                            expect_cycle("t4b_issue", 0, 2'b00);
    drain();
    check_perf("perf_t1_t4");

    // T5: r0 is never tracked; invalid ID never stalls.
    lw(5'd0);               expect_cycle("t5_lw0", 0, 2'b00);
    beq(5'd0, 5'd0);        expect_cycle("t5_beq0", 0, 2'b00);
    lw(5'd8);               expect_cycle("t5_lw8", 0, 2'b00);
    beq(5'd8, 5'd8); id_valid = 1'b0;
                            expect_cycle("t5_inv1", 0, 2'b00);
                            expect_cycle("t5_inv2", 0, 2'b00);
    drain();

    // T6: reset during the first lw/beq bubble clears the hazard asynchronously.
    lw(5'd8);               expect_cycle("t6_lw", 0, 2'b00);
    beq(5'd8, 5'd0);
    @(negedge clk);
    check("t6_pre_cause", {30'd0, stall_cause}, 32'd2);
    check("t6_pre_pc",    {31'd0, pc_write},    32'd0);
    rst_n = 1'b0; exp_perf = 0;
    #1;
    check("t6_rst_pc",    {31'd0, pc_write},    32'd1);
    check("t6_rst_ctl",   {31'd0, control_dst}, 32'd1);
    check("t6_rst_cause", {30'd0, stall_cause}, 32'd0);
    check_perf("t6_rst_perf");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    expect_cycle("t6_issue", 0, 2'b00);
    drain();
    check_perf("t6_perf");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
